// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, alu_op bit
// positions and the divider state encoding.
package exe_stage_pkg;

    localparam int DS_ES_W      = 155;
    localparam int ES_MS_W      = 71;
    localparam int RF_COLLECT_W = 39;
    localparam int XLEN         = 32;

    // alu_op bit positions
    localparam int OP_MUL_W   = 18;
    localparam int OP_MULH_W  = 17;
    localparam int OP_MULH_WU = 16;
    localparam int OP_DIV_W   = 15;
    localparam int OP_MOD_W   = 14;
    localparam int OP_DIV_WU  = 13;
    localparam int OP_MOD_WU  = 12;
    localparam int OP_LUI     = 11;
    localparam int OP_SRA     = 10;
    localparam int OP_SRL     = 9;
    localparam int OP_SLL     = 8;
    localparam int OP_XOR     = 7;
    localparam int OP_OR      = 6;
    localparam int OP_NOR     = 5;
    localparam int OP_AND     = 4;
    localparam int OP_SLTU    = 3;
    localparam int OP_SLT     = 2;
    localparam int OP_SUB     = 1;
    localparam int OP_ADD     = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Decode-to-execute bus, MSB first
    typedef struct packed {
        logic [18:0] alu_op;
        logic        res_from_mem;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        mem_we;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } ds_es_bus_t;

    // Magnitude of a 32-bit operand; unsigned operations pass it through raw.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// div_iter: iterative radix-2 restoring divider. One quotient bit per cycle
// on operand magnitudes, sign correction applied to the held result.
module exe_stage_div_iter
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_CNT = 5'(DIV_CYCLES - 1);

    div_state_e  state_q;
    logic        done_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] dvd_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dvz_q;

    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        rem_ge;
    logic [31:0] rem_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", which leaves the quotient all ones.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        rem_d     = rem_ge ? rem_sub[31:0] : rem_shift[31:0];
    end

    // Divider FSM with counter and operand/sign capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= mag32(dividend, signed_op);
                        dvs_q   <= mag32(divisor, signed_op);
                        dvd_q   <= dividend;
                        q_neg_q <= signed_op & (dividend[31] ^ divisor[31]);
                        r_neg_q <= signed_op & dividend[31];
                        dvz_q   <= (divisor == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[30:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DIV_DONE;
                        done_q  <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state_q <= DIV_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sign-correct the held magnitudes; divide-by-zero overrides sign rules.
    always_comb begin
        if (dvz_q) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dvd_q;
        end else begin
            quotient  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
            remainder = r_neg_q ? (~rem_q + 32'd1) : rem_q;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU / multiply / divide
// results, drives the data-SRAM request and reports forwarding info back
// to decode.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ds_to_es_valid,
    output logic                    es_allowin,
    input  logic [DS_ES_W-1:0]      ds_to_es_bus,
    input  logic                    ms_allowin,
    output logic                    es_to_ms_valid,
    output logic [ES_MS_W-1:0]      es_to_ms_bus,
    output logic [RF_COLLECT_W-1:0] es_rf_collect,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_we,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    logic       es_valid_q, es_valid_d;
    ds_es_bus_t bus_q, bus_d;

    logic        es_ready_go;
    logic        is_divmod;
    logic        div_signed;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    logic        mul_sext;
    logic        not_ready;

    assign is_divmod  = bus_q.alu_op[OP_DIV_W] | bus_q.alu_op[OP_MOD_W]
                      | bus_q.alu_op[OP_DIV_WU] | bus_q.alu_op[OP_MOD_WU];
    assign div_signed = bus_q.alu_op[OP_DIV_W] | bus_q.alu_op[OP_MOD_W];

    assign es_ready_go    = ~is_divmod | div_done;
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    // Next-state for the valid bit and the latched decode bus.
    always_comb begin
        es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
        bus_d      = (ds_to_es_valid & es_allowin) ? ds_es_bus_t'(ds_to_es_bus) : bus_q;
    end

    // Pipeline register between decode and execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
        end
    end

    // Twelve-op ALU; lui takes the immediate already positioned by decode in src2.
    always_comb begin
        alu_result = '0;
        if (bus_q.alu_op[OP_ADD])       alu_result = bus_q.src1 + bus_q.src2;
        else if (bus_q.alu_op[OP_SUB])  alu_result = bus_q.src1 - bus_q.src2;
        else if (bus_q.alu_op[OP_SLT])  alu_result = {31'd0, $signed(bus_q.src1) < $signed(bus_q.src2)};
        else if (bus_q.alu_op[OP_SLTU]) alu_result = {31'd0, bus_q.src1 < bus_q.src2};
        else if (bus_q.alu_op[OP_AND])  alu_result = bus_q.src1 & bus_q.src2;
        else if (bus_q.alu_op[OP_NOR])  alu_result = ~(bus_q.src1 | bus_q.src2);
        else if (bus_q.alu_op[OP_OR])   alu_result = bus_q.src1 | bus_q.src2;
        else if (bus_q.alu_op[OP_XOR])  alu_result = bus_q.src1 ^ bus_q.src2;
        else if (bus_q.alu_op[OP_SLL])  alu_result = bus_q.src1 << bus_q.src2[4:0];
        else if (bus_q.alu_op[OP_SRL])  alu_result = bus_q.src1 >> bus_q.src2[4:0];
        else if (bus_q.alu_op[OP_SRA])  alu_result = 32'($signed(bus_q.src1) >>> bus_q.src2[4:0]);
        else if (bus_q.alu_op[OP_LUI])  alu_result = bus_q.src2;
    end

    // 33x33 signed multiply: operands are extended by one bit (sign or zero,
    // mulh.wu zero-extends) and only the low 64 product bits are ever needed,
    // so the product is formed directly at 64 bits.
    always_comb begin
        mul_sext = ~bus_q.alu_op[OP_MULH_WU];
        mul_a    = {{32{mul_sext & bus_q.src1[31]}}, bus_q.src1};
        mul_b    = {{32{mul_sext & bus_q.src2[31]}}, bus_q.src2};
        mul_prod = mul_a * mul_b;
    end

    exe_stage_div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid_q & is_divmod),
        .signed_op (div_signed),
        .dividend  (bus_q.src1),
        .divisor   (bus_q.src2),
        .ack       (ms_allowin),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Final result select.
    always_comb begin
        es_result = alu_result;
        if (bus_q.alu_op[OP_MUL_W])                                   es_result = mul_prod[31:0];
        else if (bus_q.alu_op[OP_MULH_W] | bus_q.alu_op[OP_MULH_WU])  es_result = mul_prod[63:32];
        else if (bus_q.alu_op[OP_DIV_W] | bus_q.alu_op[OP_DIV_WU])    es_result = div_quo;
        else if (bus_q.alu_op[OP_MOD_W] | bus_q.alu_op[OP_MOD_WU])    es_result = div_rem;
    end

    // Loads and unfinished divides are not forwardable; decode stalls on them.
    assign not_ready = es_valid_q & (bus_q.res_from_mem | (is_divmod & ~div_done));

    assign es_to_ms_bus  = {bus_q.res_from_mem, bus_q.rf_we, bus_q.rf_waddr, es_result, bus_q.pc};
    assign es_rf_collect = {not_ready, es_valid_q & bus_q.rf_we, bus_q.rf_waddr, es_result};

    assign data_sram_en    = es_valid_q & ms_allowin & (bus_q.res_from_mem | bus_q.mem_we);
    assign data_sram_we    = {4{es_valid_q & bus_q.mem_we & ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = bus_q.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected memory-stage buses are queued at
// issue time and popped by a monitor whenever an instruction leaves.
module tb_exe_stage;

    localparam int T_MUL_W = 18, T_MULH_W = 17, T_MULH_WU = 16;
    localparam int T_DIV_W = 15, T_MOD_W = 14, T_DIV_WU = 13, T_MOD_WU = 12;
    localparam int T_ADD = 0, T_SUB = 1, T_SLT = 2, T_SLTU = 3, T_AND = 4, T_NOR = 5;
    localparam int T_OR = 6, T_XOR = 7, T_SLL = 8, T_SRL = 9, T_SRA = 10, T_LUI = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic         ds_to_es_valid;
    logic         es_allowin;
    logic [154:0] ds_to_es_bus;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_rf_collect;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks   = 0;
    int failures = 0;

    logic [70:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        string       n;
    } vec_t;

    vec_t vecs[11];

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_to_es_bus    (ds_to_es_bus),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_rf_collect   (es_rf_collect),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [70:0] got, input logic [70:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every departing instruction is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && es_to_ms_valid && ms_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%0h exp=none", es_to_ms_bus);
            end else begin
                logic [70:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (es_to_ms_bus !== e) begin
                    failures++;
                    $display("FAIL %s got=%0h exp=%0h", n, es_to_ms_bus, e);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that
    // latched the instruction (its entry cycle).
    task automatic issue(input string name, input int op_bit, input logic rfm,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic mw, input logic rw, input logic [4:0] wa,
                         input logic [31:0] rkd, input logic [31:0] pc,
                         input logic [31:0] res);
        logic [18:0] op;
        int          n;
        op = '0;
        op[op_bit] = 1'b1;
        exp_q.push_back({rfm, rw, wa, res, pc});
        name_q.push_back(name);
        ds_to_es_bus   = {op, rfm, s1, s2, mw, rw, wa, rkd, pc};
        ds_to_es_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!es_allowin && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!es_allowin) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout got=0 exp=1", name);
        end
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!es_to_ms_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!es_to_ms_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout got=0 exp=1", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;

        vecs[0]  = '{T_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE, "sub"};
        vecs[1]  = '{T_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         "slt"};
        vecs[2]  = '{T_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,         "sltu"};
        vecs[3]  = '{T_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, "and"};
        vecs[4]  = '{T_NOR,  32'd0,          32'd0,          32'hFFFF_FFFF, "nor"};
        vecs[5]  = '{T_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, "or"};
        vecs[6]  = '{T_XOR,  32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0, "xor"};
        vecs[7]  = '{T_SLL,  32'd1,          32'd31,         32'h8000_0000, "sll"};
        vecs[8]  = '{T_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000, "srl"};
        vecs[9]  = '{T_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000, "sra"};
        vecs[10] = '{T_LUI,  32'd0,          32'h1234_5000,  32'h1234_5000, "lui"};

        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #3;
        chk("rst_allowin",  71'(es_allowin),     71'd1);
        chk("rst_valid",    71'(es_to_ms_valid), 71'd0);
        chk("rst_sram_en",  71'(data_sram_en),   71'd0);
        chk("rst_sram_we",  71'(data_sram_we),   71'd0);
        chk("rst_collect",  71'(es_rf_collect),  71'd0);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // add: single-cycle, stage never blocks
        issue("add", T_ADD, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3, 32'd0, 32'h1C00_0000, 32'd12);
        @(negedge clk);
        chk("add_allowin", 71'(es_allowin),     71'd1);
        chk("add_valid",   71'(es_to_ms_valid), 71'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].n, vecs[i].op, 1'b0, vecs[i].a, vecs[i].b, 1'b0, 1'b1, 5'd4,
                  32'd0, 32'h1C00_0100 + 32'(i * 4), vecs[i].r);
            drain(vecs[i].n);
        end

        issue("mulh_w", T_MULH_W, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd6, 32'd0, 32'h1C00_0200, 32'hFFFF_FFFF);
        drain("mulh_w");
        issue("mulh_wu", T_MULH_WU, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd6, 32'd0, 32'h1C00_0204, 32'h0000_0001);
        drain("mulh_wu");
        issue("mul_w", T_MUL_W, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd6, 32'd0, 32'h1C00_0208, 32'hFFFF_FFFE);
        drain("mul_w");

        // div.w -7/2: blocked and not forwardable for 33 cycles
        issue("div_w", T_DIV_W, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1C00_0300, 32'hFFFF_FFFD);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (es_allowin !== 1'b0 || es_rf_collect[38] !== 1'b1 || es_to_ms_valid !== 1'b0)
                bad++;
        end
        chk("div_stall_cycles", 71'(bad), 71'd0);
        @(negedge clk);
        chk("div_valid_t33", 71'(es_to_ms_valid), 71'd1);
        chk("div_ready_t33", 71'(es_rf_collect[38]), 71'd0);
        @(posedge clk);
        #1;
        issue("mod_w", T_MOD_W, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1C00_0304, 32'hFFFF_FFFF);
        drain("mod_w");

        // back-to-back divides by zero, then the signed overflow case
        issue("div_wu_zero", T_DIV_WU, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h1C00_0400, 32'hFFFF_FFFF);
        issue("mod_wu_zero", T_MOD_WU, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h1C00_0404, 32'd100);
        drain("mod_wu_zero");
        issue("div_w_ovf", T_DIV_W, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd9, 32'd0, 32'h1C00_0408, 32'h8000_0000);
        drain("div_w_ovf");

        // store held by memory stage, then released
        ms_allowin = 1'b0;
        issue("store", T_ADD, 1'b0, 32'h10, 32'h0C, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h1C00_0500, 32'h1C);
        @(negedge clk);
        chk("st_hold_en",      71'(data_sram_en), 71'd0);
        chk("st_hold_we",      71'(data_sram_we), 71'd0);
        chk("st_hold_allowin", 71'(es_allowin),   71'd0);
        @(posedge clk);
        #1;
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("st_en",    71'(data_sram_en),    71'd1);
        chk("st_we",    71'(data_sram_we),    71'hF);
        chk("st_addr",  71'(data_sram_addr),  71'h1C);
        chk("st_wdata", 71'(data_sram_wdata), 71'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // load: request without write enables, flagged not ready for forwarding
        issue("load", T_ADD, 1'b1, 32'h100, 32'h4, 1'b0, 1'b1, 5'd5, 32'd0, 32'h1C00_0600, 32'h104);
        @(negedge clk);
        chk("ld_en",        71'(data_sram_en),      71'd1);
        chk("ld_we",        71'(data_sram_we),      71'd0);
        chk("ld_not_ready", 71'(es_rf_collect[38]), 71'd1);
        chk("ld_rf_we",     71'(es_rf_collect[37]), 71'd1);
        @(posedge clk);
        #1;

        // reset in the middle of a divide
        issue("div_aborted", T_DIV_WU, 1'b0, 32'd50, 32'd7, 1'b0, 1'b1, 5'd10, 32'd0, 32'h1C00_0700, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_state",   71'(dut.u_div.state_q), 71'd0);
        chk("mid_rst_valid",   71'(es_to_ms_valid),    71'd0);
        chk("mid_rst_allowin", 71'(es_allowin),        71'd1);
        chk("mid_rst_collect", 71'(es_rf_collect),     71'd0);
        exp_q.delete();
        name_q.delete();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        issue("div_wu_after_rst", T_DIV_WU, 1'b0, 32'd9, 32'd3, 1'b0, 1'b1, 5'd11, 32'd0, 32'h1C00_0800, 32'd3);
        n = 0;
        @(negedge clk);
        while (!es_to_ms_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("div_after_rst_latency", 71'(n), 71'd33);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 71'(exp_q.size()), 71'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
